// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage signed ALU with accumulator and valid/ready handshake
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [3:0]       s1_op_q, s1_op_d;
  logic             s1_acc_sel_q, s1_acc_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q, flags_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             transfer, accept;
  logic [WIDTH-1:0] opa, rhs, alu_res;
  logic [WIDTH:0]   sum, diff;
  logic             add_v, sub_v, alu_v, alu_c, alu_err;

  assign transfer  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready  = !rst && (!s1_valid_q || transfer);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // INC/DEC share the ADD/SUB datapath with a constant right operand of one.
  assign opa   = s1_acc_sel_q ? acc_q : s1_a_q;
  assign rhs   = (s1_op_q == 4'd3 || s1_op_q == 4'd4) ? ONE : s1_b_q;
  assign sum   = {1'b0, opa} + {1'b0, rhs};
  assign diff  = {1'b0, opa} - {1'b0, rhs};
  assign add_v = (opa[M] == rhs[M]) && (sum[M] != opa[M]);
  assign sub_v = (opa[M] != rhs[M]) && (diff[M] != opa[M]);

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    alu_err = 1'b0;
    case (s1_op_q)
      4'd0, 4'd3: begin
        alu_res = sum[M:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_v;
      end
      4'd1, 4'd4: begin
        alu_res = diff[M:0];
        alu_c   = diff[WIDTH];
        alu_v   = sub_v;
      end
      4'd2:  alu_res = opa;
      4'd5:  alu_res = ~opa;
      4'd6:  alu_res = ~(opa | s1_b_q);
      4'd7:  alu_res = opa ^ s1_b_q;
      4'd8:  alu_res = ~(opa ^ s1_b_q);
      4'd9:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) > $signed(s1_b_q))};
      4'd10: alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(s1_b_q))};
      4'd11: alu_res = {{(WIDTH-1){1'b0}}, (opa == s1_b_q)};
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_op_d      = s1_op_q;
    s1_acc_sel_d = s1_acc_sel_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    flags_d      = flags_q;
    acc_d        = acc_q;
    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_a_d       = a;
      s1_b_d       = b;
      s1_op_d      = op;
      s1_acc_sel_d = acc_sel;
    end else if (transfer) begin
      s1_valid_d = 1'b0;
    end
    if (transfer) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      flags_d     = {alu_err, alu_v, alu_c, alu_res[M], (alu_res == '0)};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    // A clear wins over the transfer load; the transferring op already used the old value.
    if (acc_clr) begin
      acc_d = '0;
    end else if (transfer) begin
      acc_d = alu_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= '0;
      s1_acc_sel_q <= 1'b0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_op_q      <= s1_op_d;
      s1_acc_sel_q <= s1_acc_sel_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      acc_q        <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe
module tb_alu_pipe;

  localparam int W    = 8;
  localparam int MAXU = (1 << W) - 1;
  localparam int MAXS = (1 << (W - 1)) - 1;
  localparam int MINS = -(1 << (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         acc_sel, acc_clr;
  logic         out_valid, out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  typedef struct {
    logic [W-1:0] r;
    logic [4:0]   f;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] model_acc;
  bit           rand_rdy = 1'b0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_sel(acc_sel), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                 input logic [3:0] opi, input logic seli);
    logic [W-1:0] x;
    int sx, sy, ux, uy, t;
    logic v, c, err;
    exp_t e;
    x  = seli ? model_acc : ai;
    sx = int'($signed(x));
    sy = int'($signed(bi));
    ux = int'(x);
    uy = int'(bi);
    v = 1'b0; c = 1'b0; err = 1'b0; t = 0;
    case (opi)
      4'd0: begin t = ux + uy; c = (t > MAXU); v = (sx + sy > MAXS) || (sx + sy < MINS); end
      4'd1: begin t = ux - uy; c = (ux < uy);  v = (sx - sy > MAXS) || (sx - sy < MINS); end
      4'd2: t = ux;
      4'd3: begin t = ux + 1; c = (ux == MAXU); v = (sx == MAXS); end
      4'd4: begin t = ux - 1; c = (ux == 0);    v = (sx == MINS); end
      4'd5: t = ~ux;
      4'd6: t = ~(ux | uy);
      4'd7: t = ux ^ uy;
      4'd8: t = ~(ux ^ uy);
      4'd9:  t = (sx > sy) ? 1 : 0;
      4'd10: t = (sx < sy) ? 1 : 0;
      4'd11: t = (sx == sy) ? 1 : 0;
      default: begin t = 0; err = 1'b1; end
    endcase
    e.r = t[W-1:0];
    e.f = {err, v, c, e.r[W-1], (e.r == '0)};
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [3:0] opi,
                       input logic seli, input bit use_exp, input logic [W-1:0] er,
                       input logic [4:0] ef);
    exp_t e;
    bit done = 1'b0;
    a = ai; b = bi; op = opi; acc_sel = seli; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (use_exp) begin
          e.r = er;
          e.f = ef;
        end else begin
          e = model(ai, bi, opi, seli);
        end
        sb.push_back(e);
        model_acc = e.r;
        done = 1'b1;
      end
      tick();
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) tick();
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("extra_output", 32'(result), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'(result), 32'(mon_e.r));
        check("flags", 32'(flags), 32'(mon_e.f));
      end
    end
  end

  initial begin
    int n_acc;
    in_valid = 1'b0; a = '0; b = '0; op = '0; acc_sel = 1'b0; acc_clr = 1'b0;
    out_ready = 1'b1; rst = 1'b1; model_acc = '0;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
    tick();

    // accumulator chain, clear, and clear coinciding with a transfer
    drive(8'd0, 8'd0, 4'd3, 1'b1, 1'b1, 8'd1, 5'b00000);
    drive(8'd0, 8'd0, 4'd3, 1'b1, 1'b1, 8'd2, 5'b00000);
    drive(8'd0, 8'd0, 4'd3, 1'b1, 1'b1, 8'd3, 5'b00000);
    drain();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_acc = '0;
    drive(8'd0, 8'd0, 4'd3, 1'b1, 1'b1, 8'd1, 5'b00000);
    drive(8'd0, 8'd0, 4'd3, 1'b1, 1'b1, 8'd2, 5'b00000);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_acc = '0;
    drain();
    drive(8'd0, 8'd0, 4'd3, 1'b1, 1'b1, 8'd1, 5'b00000);
    drain();

    // ADD overflow and two-edge latency
    drive(8'd127, 8'd1, 4'd0, 1'b0, 1'b1, 8'h80, 5'b01010);
    check("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_result", 32'(result), 32'h80);

    // compares, illegal op, NOT
    drive(8'hFB, 8'h01, 4'd9,  1'b0, 1'b1, 8'd0, 5'b00001);
    drive(8'hFB, 8'h01, 4'd10, 1'b0, 1'b1, 8'd1, 5'b00000);
    drive(8'hFB, 8'hFB, 4'd11, 1'b0, 1'b1, 8'd1, 5'b00000);
    drive(8'h00, 8'h02, 4'd11, 1'b0, 1'b1, 8'd0, 5'b00001);
    drive(8'h12, 8'h34, 4'd13, 1'b0, 1'b1, 8'd0, 5'b10001);
    drive(8'h80, 8'h00, 4'd5,  1'b0, 1'b1, 8'h7F, 5'b00000);
    drain();

    // backpressure: consumer stalled for 4 cycles with continuous requests
    out_ready = 1'b0;
    n_acc = 0;
    a = 8'd10; b = 8'd3; op = 4'd1; acc_sel = 1'b0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(a, b, op, acc_sel));
        model_acc = sb[sb.size()-1].r;
        n_acc++;
      end
      if (cyc >= 2) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_hold", 32'(result), 32'(sb[0].r));
      end
      tick();
      a = W'(10 + 7 * n_acc); b = W'(3 + n_acc);
    end
    check("bp_accepts", 32'(n_acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    drain();

    // random traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      drive(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'b0, '0, '0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();

    // reset with both stages full
    out_ready = 1'b0;
    drive(8'd5, 8'd3, 4'd0, 1'b0, 1'b0, '0, '0);
    drive(8'd9, 8'd4, 4'd7, 1'b0, 1'b0, '0, '0);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_flags", 32'(flags), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    model_acc = '0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("ready_after_mid_rst", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("no_stale_output", 32'(out_valid), 32'd0);
    drive(8'd0, 8'd0, 4'd3, 1'b1, 1'b1, 8'd1, 5'b00000);
    drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
